alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised, handshaked successor to the single-cycle datapath ALU. It keeps the existing `{opcode, opext}` encoding and CLFZN flag semantics and registers its result. It adds multi-cycle operations (iterative multiply, variable-amount shift) and a persistent carry register that revives add-with-carry. It sits between the register-file read stage and writeback, and stalls issue through a valid/ready handshake.

## Interface
- `WIDTH`, 16: datapath width in bits. Must be at least 4.
- `SHW`, $clog2(WIDTH): width of the shift-amount field.
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: operation offered this cycle.
- `in_ready` out 1: operation accepted when `in_valid & in_ready` on a rising edge.
- `A`, `B` in WIDTH: operands. Immediates are already extended by the decoder.
- `opcode`, `opext` in 4 each: operation select.
- `out_valid` out 1: result and flags valid.
- `out_ready` in 1: consumer takes the result when `out_valid & out_ready`.
- `S` out WIDTH: registered result.
- `CLFZN` out 5: registered flags; bit4 C, bit3 L, bit2 F, bit1 Z, bit0 N.
- `carry_q` out 1: persistent carry register, visible for debug and stall logic.

## Operation
- Single-cycle operations keep the existing encodings and results:
  - ADD 0000_0101 / ADDI 0101_x: C = carry out; F = signed overflow, computed as (~A&~B&S)|(A&B&~S) on the MSBs for both.
  - ADDU 0000_0110 / ADDUI 0110_x: C = F = carry out.
  - SUB 0000_1001 / SUBI 1001_x: S = A-B; F = 1 when A[MSB]≠B[MSB] and S[MSB]=B[MSB]; C = 1 on borrow (A<B unsigned).
  - CMP 0011_x / CMPI 1011_x: S = 0; L = A>B unsigned; Z = A==B; N = A>B signed; C = F = 0.
  - AND 0000_0001, OR 0000_0010, XOR 0000_0011.
  - NOT 0000_0100: bitwise ~A.
  - LSH 0000_1100 and ALSH 0000_0111: A<<1, zero fill.
  - RSH 0000_1110 / RSHI 1110_x: A>>1, zero fill.
  - ARSH 0000_1000: {A[MSB], A[MSB:1]}.
  - MOV 0000_1101 / MOVI 1000_x: S = A.
- New operations:
  - ADDC 0000_1010: S = A+B+carry_q; C and F as for ADD.
  - MUL 0000_1011: S = low WIDTH bits of A*B, unsigned shift-add. C = 1 when the high half is non-zero.
  - SHN 0000_1111: amount = B[SHW-1:0]. B[WIDTH-1] = 0 shifts logically left; B[WIDTH-1] = 1 shifts logically right.
- All other encodings, including NOP, are accepted and produce S = 0, CLFZN = 0, with latency 1.
- Z is set only by CMP/CMPI. All flags not listed for an operation are 0.
- `carry_q` loads CLFZN[4] when an ADD, ADDI, ADDU, ADDUI, ADDC, SUB or SUBI result completes. All other operations leave it unchanged.
- FSM states:
  - IDLE: accepts an operation. Single-cycle ops write the output register directly; MUL goes to MULT; SHN with amount ≥ 1 goes to SHIFT; SHN with amount 0 completes like a single-cycle op (S = A).
  - MULT: iterates one bit per cycle for WIDTH cycles, then writes the output register and returns to IDLE.
  - SHIFT: shifts one bit per cycle for `amount` cycles, then writes the output register and returns to IDLE.
- `in_ready` = (state==IDLE) & (~out_valid | out_ready).
- The output register is single-entry and holds S, CLFZN and out_valid until drained.

## Timing
- Reset values: S = 0, CLFZN = 0, out_valid = 0, carry_q = 0, state = IDLE. Reset mid-MULT or mid-SHIFT abandons the operation, and the abandoned op does not update carry_q.
- Latency is measured from the accept edge to the first cycle out_valid = 1:
  - single-cycle ops: 1 cycle;
  - MUL: WIDTH+1 cycles;
  - SHN: amount+1 cycles.
- Throughput for single-cycle ops is 1 per cycle while out_ready = 1.
- While out_valid = 1 and out_ready = 0, S and CLFZN hold stable and in_ready = 0.
- A drain and a new accept in the same cycle is legal; the new result appears the next cycle.
- A multi-cycle op whose result is ready while the output is still held waits in its final state. It does not overwrite the held result.
- ADDC samples carry_q at its accept edge. Because only one op is in flight, carry_q always reflects the previous completed op.
- Inputs are ignored when in_ready = 0.

## Structure
- Package `alu_pkg`:
  - 8-bit operation constants for every encoding above;
  - flag bit indices C=4, L=3, F=2, Z=1, N=0;
  - FSM state enum.
- Sub-module `alu_iter`:
  - holds the multi-cycle MUL/SHN datapath (accumulator, shift register, down-counter) with start/done handshake;
  - the top level holds the decode, single-cycle datapath, carry_q and output register.

## Test plan
- Reset, then ADD A=16'h7FFF, B=16'h0001 -> S=16'h8000, CLFZN=5'b00100 one cycle after accept; carry_q=0.
- ADDU 16'hFFFF + 16'h0002, then ADDC 16'h0001 + 16'h0001 -> first S=16'h0001 with C=F=1; then S=16'h0003.
- MUL 16'h0123 × 16'h0010 -> S=16'h1230, C=0, out_valid 17 cycles after accept, in_ready low throughout. MUL 16'h8000 × 2 -> S=0, C=1.
- SHN A=16'h00F0 with B=16'h8004 -> S=16'h000F after 5 cycles. B=16'h0000 -> S=16'h00F0 after 1 cycle.
- Back-to-back CMP with out_ready held low for 3 cycles -> S and CLFZN stable, in_ready=0. CMP 16'hFFFF vs 16'h0001 -> CLFZN=5'b01000.
- Assert reset_n low for 1 cycle midway through a MUL -> out_valid=0 and carry_q=0 immediately. The next ADD completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: operation encodings, flag bit indices and FSM states shared by alu_seq
package alu_pkg;
   localparam logic [7:0] OP_AND = 8'h01, OP_OR = 8'h02, OP_XOR = 8'h03, OP_NOT = 8'h04;
   localparam logic [7:0] OP_ADD = 8'h05, OP_ADDU = 8'h06, OP_ALSH = 8'h07, OP_ARSH = 8'h08;
   localparam logic [7:0] OP_SUB = 8'h09, OP_ADDC = 8'h0A, OP_MUL = 8'h0B, OP_LSH = 8'h0C;
   localparam logic [7:0] OP_MOV = 8'h0D, OP_RSH = 8'h0E, OP_SHN = 8'h0F;
   localparam logic [7:0] OP_CMP = 8'h30, OP_ADDI = 8'h50, OP_ADDUI = 8'h60, OP_MOVI = 8'h80;
   localparam logic [7:0] OP_SUBI = 8'h90, OP_CMPI = 8'hB0, OP_RSHI = 8'hE0;
   localparam int FC = 4, FL = 3, FF = 2, FZ = 1, FN = 0;
   typedef enum logic [1:0] {IDLE, MULT, SHIFT} state_t;
   function automatic logic add_ovf(input logic a, input logic b, input logic s);
      return (~a & ~b & s) | (a & b & ~s);
   endfunction
endpackage

// File: rtl/alu_iter.sv
// alu_iter: iterative shift-add multiplier and one-bit-per-cycle shifter; the first step happens on start
module alu_iter #(
   parameter int WIDTH = 16,
   parameter int SHW = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic             mul,
   input  logic             right,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [SHW-1:0]   amt,
   output logic             done,
   output logic [WIDTH-1:0] res,
   output logic             hi_nz
);
   logic [2*WIDTH-1:0] acc, mcand;
   logic [WIDTH-1:0] mplier;
   logic [SHW:0] cnt;
   logic mul_q, right_q;
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         acc <= '0;
         mcand <= '0;
         mplier <= '0;
         cnt <= '0;
         mul_q <= 1'b0;
         right_q <= 1'b0;
      end else if (start) begin
         acc <= mul ? (b[0] ? {{WIDTH{1'b0}}, a} : '0) : right ? {{WIDTH{1'b0}}, a >> 1} : {{WIDTH{1'b0}}, a} << 1;
         mcand <= {{WIDTH{1'b0}}, a} << 1;
         mplier <= b >> 1;
         cnt <= mul ? (SHW+1)'(WIDTH-1) : {1'b0, amt} - (SHW+1)'(1);
         mul_q <= mul;
         right_q <= right;
      end else if (cnt != '0) begin
         cnt <= cnt - (SHW+1)'(1);
         mcand <= mcand << 1;
         mplier <= mplier >> 1;
         acc <= mul_q ? acc + (mplier[0] ? mcand : '0) : right_q ? acc >> 1 : acc << 1;
      end
   assign done = cnt == '0;
   assign res = acc[WIDTH-1:0];
   assign hi_nz = |acc[2*WIDTH-1:WIDTH];
endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with registered result, persistent carry and iterative MUL/SHN
module alu_seq import alu_pkg::*; #(
   parameter int WIDTH = 16,
   parameter int SHW = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [3:0]       opcode,
   input  logic [3:0]       opext,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] S,
   output logic [4:0]       CLFZN,
   output logic             carry_q
);
   localparam int M = WIDTH - 1;
   state_t state_q, state_d;
   logic [7:0] op;
   logic [WIDTH:0] add_r, adc_r, sub_r;
   logic [WIDTH-1:0] s_c, s_d, res;
   logic [4:0] f_c, f_d;
   logic cw, accept, out_free, load, start, is_mul, multi, done, hi_nz;
   // immediate forms fold onto their register-form encodings
   assign op = opcode == 4'h0 ? {opcode, opext} :
               opcode == OP_ADDI[7:4] ? OP_ADD :
               opcode == OP_ADDUI[7:4] ? OP_ADDU :
               opcode == OP_SUBI[7:4] ? OP_SUB :
               (opcode == OP_CMP[7:4] || opcode == OP_CMPI[7:4]) ? OP_CMP :
               opcode == OP_MOVI[7:4] ? OP_MOV :
               opcode == OP_RSHI[7:4] ? OP_RSH : 8'h00;
   assign add_r = {1'b0, A} + {1'b0, B};
   assign adc_r = add_r + {{WIDTH{1'b0}}, carry_q};
   assign sub_r = {1'b0, A} - {1'b0, B};
   assign is_mul = op == OP_MUL;
   assign multi = is_mul | (op == OP_SHN & |B[SHW-1:0]);
   assign out_free = ~out_valid | out_ready;
   assign in_ready = state_q == IDLE & out_free;
   assign accept = in_valid & in_ready;
   always_comb begin
      s_c = '0;
      f_c = '0;
      cw = 1'b0;
      case (op)
         OP_ADD: begin
            s_c = add_r[M:0];
            f_c[FC] = add_r[WIDTH];
            f_c[FF] = add_ovf(A[M], B[M], add_r[M]);
            cw = 1'b1;
         end
         OP_ADDC: begin
            s_c = adc_r[M:0];
            f_c[FC] = adc_r[WIDTH];
            f_c[FF] = add_ovf(A[M], B[M], adc_r[M]);
            cw = 1'b1;
         end
         OP_ADDU: begin
            s_c = add_r[M:0];
            f_c[FC] = add_r[WIDTH];
            f_c[FF] = add_r[WIDTH];
            cw = 1'b1;
         end
         OP_SUB: begin
            s_c = sub_r[M:0];
            f_c[FC] = sub_r[WIDTH];
            f_c[FF] = (A[M] != B[M]) & (sub_r[M] == B[M]);
            cw = 1'b1;
         end
         OP_CMP: f_c = {1'b0, A > B, 1'b0, A == B, $signed(A) > $signed(B)};
         OP_AND: s_c = A & B;
         OP_OR: s_c = A | B;
         OP_XOR: s_c = A ^ B;
         OP_NOT: s_c = ~A;
         OP_LSH, OP_ALSH: s_c = A << 1;
         OP_RSH: s_c = A >> 1;
         OP_ARSH: s_c = {A[M], A[M:1]};
         OP_MOV, OP_SHN: s_c = A;
         default: ;
      endcase
   end
   always_comb begin
      state_d = state_q;
      start = 1'b0;
      load = 1'b0;
      s_d = s_c;
      f_d = f_c;
      case (state_q)
         IDLE: if (accept) begin
            start = multi;
            load = ~multi;
            state_d = multi ? (is_mul ? MULT : SHIFT) : IDLE;
         end
         default: if (done & out_free) begin
            load = 1'b1;
            s_d = res;
            f_d = {state_q == MULT & hi_nz, 4'b0};
            state_d = IDLE;
         end
      endcase
   end
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) state_q <= IDLE;
      else state_q <= state_d;
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         S <= '0;
         CLFZN <= '0;
         out_valid <= 1'b0;
         carry_q <= 1'b0;
      end else begin
         if (load) begin
            S <= s_d;
            CLFZN <= f_d;
         end
         out_valid <= load | (out_valid & ~out_ready);
         if (accept & cw) carry_q <= f_c[FC];
      end
   alu_iter #(.WIDTH(WIDTH), .SHW(SHW)) u_iter (
      .clk(clk), .reset_n(reset_n), .start(start), .mul(is_mul), .right(B[M]),
      .a(A), .b(B), .amt(B[SHW-1:0]), .done(done), .res(res), .hi_nz(hi_nz)
   );
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed plus random scoreboard bench for alu_seq against an arithmetic reference model
module tb_alu_seq;
   logic clk = 0, reset_n = 0, in_valid = 0, out_ready = 1;
   logic [15:0] A = 0, B = 0, S;
   logic [3:0] opcode = 0, opext = 0;
   logic in_ready, out_valid, carry_q;
   logic [4:0] CLFZN;
   int total = 0, passed = 0;
   logic [20:0] exp_q[$];
   logic [20:0] mon_e;
   logic mcarry = 0;
   bit rand_ready = 0;
   always #5 clk = ~clk;
   alu_seq dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
      .A(A), .B(B), .opcode(opcode), .opext(opext), .out_valid(out_valid),
      .out_ready(out_ready), .S(S), .CLFZN(CLFZN), .carry_q(carry_q)
   );
   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) $display("FAIL %s got=%h want=%h", name, got, want);
      else passed++;
   endtask
   function automatic logic [20:0] model(input logic [3:0] oc, input logic [3:0] oe,
                                         input logic [15:0] a, input logic [15:0] b,
                                         input logic cin, output logic upd);
      logic [15:0] s;
      logic c, l, fv, z, n;
      int sa, sb, ua, ub, r;
      longint p;
      sa = int'($signed(a));
      sb = int'($signed(b));
      ua = int'(a);
      ub = int'(b);
      s = 0; c = 0; l = 0; fv = 0; z = 0; n = 0; upd = 0;
      if (oc == 4'h5 || (oc == 0 && oe == 4'h5)) begin
         r = ua + ub; s = r[15:0]; c = r > 65535; upd = 1;
         fv = (sa + sb) > 32767 || (sa + sb) < -32768;
      end else if (oc == 0 && oe == 4'hA) begin
         r = ua + ub + int'(cin); s = r[15:0]; c = r > 65535; upd = 1;
         fv = (sa + sb + int'(cin)) > 32767 || (sa + sb + int'(cin)) < -32768;
      end else if (oc == 4'h6 || (oc == 0 && oe == 4'h6)) begin
         r = ua + ub; s = r[15:0]; c = r > 65535; fv = c; upd = 1;
      end else if (oc == 4'h9 || (oc == 0 && oe == 4'h9)) begin
         r = ua - ub; s = r[15:0]; c = ua < ub; upd = 1;
         fv = (sa - sb) > 32767 || (sa - sb) < -32768;
      end else if (oc == 4'h3 || oc == 4'hB) begin
         l = ua > ub; z = ua == ub; n = sa > sb;
      end else if (oc == 4'h8 || (oc == 0 && oe == 4'hD)) s = a;
      else if (oc == 4'hE || (oc == 0 && oe == 4'hE)) s = a >> 1;
      else if (oc == 0) begin
         case (oe)
            4'h1: s = a & b;
            4'h2: s = a | b;
            4'h3: s = a ^ b;
            4'h4: s = ~a;
            4'h7, 4'hC: s = a << 1;
            4'h8: begin r = sa >>> 1; s = r[15:0]; end
            4'hB: begin p = longint'(ua) * longint'(ub); s = p[15:0]; c = p > 65535; end
            4'hF: s = b[15] ? a >> b[3:0] : a << b[3:0];
            default: ;
         endcase
      end
      return {s, c, l, fv, z, n};
   endfunction
   task automatic issue(input logic [3:0] oc, input logic [3:0] oe, input logic [15:0] a, input logic [15:0] b);
      logic upd;
      logic [20:0] e;
      int n = 0;
      opcode = oc; opext = oe; A = a; B = b; in_valid = 1;
      @(negedge clk);
      while (!in_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         check("issue_timeout", 0, 1);
         in_valid = 0;
         return;
      end
      e = model(oc, oe, a, b, mcarry, upd);
      if (upd) mcarry = e[4];
      exp_q.push_back(e);
      @(posedge clk);
      #1 in_valid = 0;
   endtask
   task automatic wait_out(output int n, output bit ir_bad);
      n = 1;
      ir_bad = 0;
      while (!out_valid && n < 100) begin
         if (in_ready) ir_bad = 1;
         @(posedge clk);
         #1 n++;
      end
   endtask
   always @(negedge clk)
      if (reset_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) check("unexpected_output", 1, 0);
         else begin
            mon_e = exp_q.pop_front();
            check("scoreboard", {11'b0, S, CLFZN}, {11'b0, mon_e});
         end
      end
   always @(posedge clk)
      if (rand_ready) begin
         #1 out_ready = $urandom_range(0, 3) != 0;
      end
   initial begin
      int n;
      bit bad;
      logic [15:0] s0;
      logic [4:0] f0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_S", S, 0);
      check("rst_flags", CLFZN, 0);
      check("rst_valid", out_valid, 0);
      check("rst_carry", carry_q, 0);
      reset_n = 1;
      @(posedge clk);
      #1 issue(4'h0, 4'h5, 16'h7FFF, 16'h0001);
      check("add_valid", out_valid, 1);
      check("add_S", S, 16'h8000);
      check("add_flags", CLFZN, 5'b00100);
      check("add_carry", carry_q, 0);
      issue(4'h0, 4'h6, 16'hFFFF, 16'h0002);
      check("addu_S", S, 16'h0001);
      check("addu_flags", CLFZN, 5'b10100);
      check("addu_carry", carry_q, 1);
      issue(4'h0, 4'hA, 16'h0001, 16'h0001);
      check("addc_S", S, 16'h0003);
      check("addc_flags", CLFZN, 5'b00000);
      check("addc_carry", carry_q, 0);
      issue(4'h0, 4'hB, 16'h0123, 16'h0010);
      wait_out(n, bad);
      check("mul_latency", n, 17);
      check("mul_in_ready_low", bad, 0);
      check("mul_S", S, 16'h1230);
      check("mul_flags", CLFZN, 5'b00000);
      issue(4'h0, 4'hB, 16'h8000, 16'h0002);
      wait_out(n, bad);
      check("mul_hi_S", S, 16'h0000);
      check("mul_hi_flags", CLFZN, 5'b10000);
      issue(4'h0, 4'hF, 16'h00F0, 16'h8004);
      wait_out(n, bad);
      check("shn_latency", n, 5);
      check("shn_S", S, 16'h000F);
      issue(4'h0, 4'hF, 16'h00F0, 16'h0000);
      wait_out(n, bad);
      check("shn0_latency", n, 1);
      check("shn0_S", S, 16'h00F0);
      issue(4'h3, 4'h0, 16'hFFFF, 16'h0001);
      out_ready = 0;
      s0 = S;
      f0 = CLFZN;
      check("cmp_S", S, 16'h0000);
      check("cmp_flags", CLFZN, 5'b01000);
      opcode = 4'hB; opext = 4'h0; A = 16'h0005; B = 16'h0005; in_valid = 1;
      bad = 0;
      repeat (3) begin
         @(posedge clk);
         #1 if (S !== s0 || CLFZN !== f0 || in_ready !== 1'b0 || out_valid !== 1'b1) bad = 1;
      end
      check("stall_hold", bad, 0);
      out_ready = 1;
      issue(4'hB, 4'h0, 16'h0005, 16'h0005);
      check("cmpi_eq_flags", CLFZN, 5'b00010);
      issue(4'h0, 4'h6, 16'hFFFF, 16'h0002);
      check("pre_rst_carry", carry_q, 1);
      issue(4'h0, 4'hB, 16'h0003, 16'h0005);
      repeat (5) @(posedge clk);
      #1 reset_n = 0;
      #1;
      check("midmul_rst_valid", out_valid, 0);
      check("midmul_rst_carry", carry_q, 0);
      exp_q.delete();
      mcarry = 0;
      @(posedge clk);
      #1 reset_n = 1;
      @(posedge clk);
      #1 issue(4'h0, 4'h5, 16'h0002, 16'h0003);
      check("post_rst_valid", out_valid, 1);
      check("post_rst_S", S, 16'h0005);
      rand_ready = 1;
      repeat (300) issue($urandom_range(0, 1) != 0 ? 4'h0 : 4'($urandom_range(1, 15)),
                         4'($urandom), 16'($urandom), 16'($urandom));
      rand_ready = 0;
      @(posedge clk);
      #2 out_ready = 1;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(posedge clk);
         n++;
      end
      check("drain", exp_q.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
